// File: rtl/reg_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_streamer
// Brief    : Sweeps the CPU debug port and streams every register as bytes.
//            Frame: HEADER, 4 bytes per register (MSB first), XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_streamer #(
    parameter int          NUM_REGS = 32,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] c_LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_SEL  = 3'd2,
        S_CAP  = 3'd3,
        S_SEND = 3'd4,
        S_CSUM = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_idx;
    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic [7:0]  r_csum;
    logic        w_xfer;

    assign w_xfer  = out_valid & out_ready;
    assign reg_sel = r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = HEADER;
                if (w_xfer) begin
                    w_next = S_SEL;
                end
            end
            S_SEL: begin
                w_next = S_CAP;
            end
            S_CAP: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = r_shift[31:24];
                if (w_xfer && r_cnt == 2'd3) begin
                    w_next = (r_idx == c_LAST) ? S_CSUM : S_SEL;
                end
            end
            S_CSUM: begin
                out_valid = 1'b1;
                out_data  = r_csum;
                if (w_xfer) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // reg_data is sampled only in CAP, so the CPU value may move freely elsewhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 5'd0;
            r_shift <= 32'd0;
            r_cnt   <= 2'd0;
            r_csum  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx  <= 5'd0;
                        r_csum <= 8'd0;
                    end
                end
                S_CAP: begin
                    r_shift <= reg_data;
                    r_cnt   <= 2'd0;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_csum  <= r_csum ^ r_shift[31:24];
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3 && r_idx != c_LAST) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_idx <= 5'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_streamer
// Brief    : Directed self-checking bench for reg_dump_streamer (2 and 32 regs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start2, start32;
    logic [4:0]  reg_sel2, reg_sel32;
    logic [31:0] reg_data2, reg_data32;
    logic [7:0]  out_data2, out_data32;
    logic        out_valid2, out_valid32, out_ready2, out_ready32;
    logic        busy2, busy32, done2, done32;
    logic [31:0] x1;

    assign reg_data2  = (reg_sel2 == 5'd1) ? x1 : 32'h0000_0000;
    assign reg_data32 = 32'h1000_0000 | {27'd0, reg_sel32};

    reg_dump_streamer #(.NUM_REGS(2), .HEADER(8'hA5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .reg_sel(reg_sel2), .reg_data(reg_data2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2), .done(done2)
    );

    reg_dump_streamer #(.NUM_REGS(32), .HEADER(8'hA5)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .reg_sel(reg_sel32), .reg_data(reg_data32),
        .out_data(out_data32), .out_valid(out_valid32), .out_ready(out_ready32),
        .busy(busy32), .done(done32)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];
    int done_at;
    logic [7:0] exp2 [10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h12, 8'h34, 8'h56, 8'h78, 8'h08};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
    endtask

    // Entered one step after the edge that sampled start (HDR cycle = cyc 1)
    task automatic run2(input int stall_n, input bit isolate, input bit repulse);
        bit stalled = 0, changed = 0, pulsed = 0, hold_ok = 1, busy_ok = 1;
        int cyc = 1;
        got.delete();
        done_at = -1;
        while (cyc < 60) begin
            if (repulse && pulsed) start2 = 1'b0;
            if (!busy2) busy_ok = 0;
            if (isolate && !changed && out_valid2 && reg_sel2 == 5'd1) begin
                x1 = 32'hFFFF_FFFF;
                changed = 1;
            end
            if (repulse && !pulsed && got.size() == 3) begin
                start2 = 1'b1;
                pulsed = 1;
            end
            if (stall_n > 0 && !stalled && out_valid2 && out_data2 == 8'h34) begin
                stalled = 1;
                out_ready2 = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    cyc++;
                    if (!(out_valid2 && out_data2 == 8'h34)) hold_ok = 0;
                end
                out_ready2 = 1'b1;
            end
            if (done2) begin
                done_at = cyc;
                break;
            end
            if (out_valid2 && out_ready2) got.push_back(out_data2);
            tick();
            cyc++;
        end
        start2 = 1'b0;
        if (stall_n > 0) check("hold_34_under_backpressure", hold_ok, 1);
        check("busy_during_frame", busy_ok, 1);
    endtask

    task automatic check_frame2(input string tag, input int exp_done);
        check({tag, "_done_cycle"}, done_at, exp_done);
        check({tag, "_len"}, got.size(), 10);
        if (got.size() == 10)
            for (int i = 0; i < 10; i++) check({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp2[i]});
    endtask

    initial begin
        int idle_bad;
        int cyc;
        int sel_bad;
        int pay_bad;
        int sel_done;
        rst = 1'b1;
        start2 = 1'b0;
        start32 = 1'b0;
        out_ready2 = 1'b1;
        out_ready32 = 1'b1;
        x1 = 32'h1234_5678;
        repeat (3) tick();
        check("rst_valid", out_valid2, 0);
        check("rst_data", out_data2, 0);
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_sel", reg_sel2, 0);
        check("rst_busy32", busy32, 0);
        rst = 1'b0;
        tick();

        // Basic two-register frame
        pulse_start2();
        check("hdr_valid", out_valid2, 1);
        check("hdr_data", out_data2, 8'hA5);
        run2(0, 0, 0);
        check_frame2("basic", 15);
        check("done_sel_zero", reg_sel2, 0);
        tick();
        check("idle_after_done_busy", busy2, 0);
        check("idle_after_done_done", done2, 0);

        // Backpressure on 0x34 for 5 cycles
        tick();
        pulse_start2();
        run2(5, 0, 0);
        check_frame2("stall", 20);

        // Capture isolation: x1 changes after CAP of register 1
        tick();
        pulse_start2();
        run2(0, 1, 0);
        check_frame2("isolate", 15);
        x1 = 32'h1234_5678;

        // start re-pulsed during SEND is ignored
        tick();
        pulse_start2();
        run2(0, 0, 1);
        check_frame2("repulse", 15);
        idle_bad = 0;
        repeat (20) begin
            tick();
            if (busy2 || out_valid2) idle_bad++;
        end
        check("no_second_frame", idle_bad, 0);

        // Reset during SEND of register 1
        pulse_start2();
        cyc = 0;
        while (!(out_valid2 && reg_sel2 == 5'd1) && cyc < 40) begin
            tick();
            cyc++;
        end
        check("reached_send_reg1", (out_valid2 && reg_sel2 == 5'd1), 1);
        rst = 1'b1;
        tick();
        check("midrst_valid", out_valid2, 0);
        check("midrst_busy", busy2, 0);
        check("midrst_sel", reg_sel2, 0);
        check("midrst_done", done2, 0);
        rst = 1'b0;
        idle_bad = 0;
        repeat (30) begin
            tick();
            if (done2 || busy2 || out_valid2) idle_bad++;
        end
        check("midrst_quiet", idle_bad, 0);
        pulse_start2();
        run2(0, 0, 0);
        check_frame2("after_rst", 15);

        // start held high: exactly one IDLE cycle between frames
        tick();
        start2 = 1'b1;
        tick();
        begin
            int c = 1;
            done_at = -1;
            while (c < 60 && !done2) begin
                tick();
                c++;
            end
            if (done2) done_at = c;
        end
        check("held_done_cycle", done_at, 15);
        tick();
        check("held_idle_gap", busy2, 0);
        tick();
        check("held_restart_busy", busy2, 1);
        check("held_restart_hdr", out_data2, 8'hA5);
        start2 = 1'b0;
        run2(0, 0, 0);
        check_frame2("held_second", 15);

        // 32-register frame
        tick();
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        got.delete();
        done_at = -1;
        sel_bad = 0;
        sel_done = -1;
        cyc = 1;
        while (cyc < 400) begin
            if (done32) begin
                done_at = cyc;
                sel_done = reg_sel32;
                break;
            end
            if (got.size() >= 1 && got.size() <= 128 && reg_sel32 != 5'((got.size() - 1) / 4))
                sel_bad++;
            if (out_valid32 && out_ready32) got.push_back(out_data32);
            tick();
            cyc++;
        end
        check("r32_done_cycle", done_at, 195);
        check("r32_len", got.size(), 130);
        check("r32_sel_track", sel_bad, 0);
        check("r32_done_sel", sel_done, 0);
        if (got.size() == 130) begin
            pay_bad = 0;
            for (int i = 0; i < 32; i++) begin
                if (got[1 + 4 * i] != 8'h10) pay_bad++;
                if (got[2 + 4 * i] != 8'h00) pay_bad++;
                if (got[3 + 4 * i] != 8'h00) pay_bad++;
                if (got[4 + 4 * i] != 8'(i)) pay_bad++;
            end
            check("r32_header", got[0], 8'hA5);
            check("r32_payload", pay_bad, 0);
            check("r32_csum", got[129], 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
